// File: rtl/scsi_seq_pkg.sv
// Shared types and constants for the SCSI byte-transfer sequencer.
package scsi_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    typedef enum logic {
        ACC_CPU = 1'b0,
        ACC_DMA = 1'b1
    } acc_t;

    // Byte pointer value of the least significant byte of a big-endian word.
    localparam logic [1:0] BO_LAST = 2'b11;

endpackage

// File: rtl/scsi_dreq_sync.sv
// Two-flop synchroniser for the asynchronous SCSI chip DMA request.
module scsi_dreq_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/scsi_xfer_sequencer.sv
// Shares the 8-bit SCSI chip port between CPU register accesses and DMA bytes,
// packing/unpacking big-endian FIFO words and generating strobes, DACK and selects.
module scsi_xfer_sequencer
    import scsi_seq_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CPUREQ,
    input  logic       CPURW,
    input  logic       DMAENA,
    input  logic       DMADIR,
    input  logic       DREQ,
    input  logic       FLUSH,
    input  logic       FIFO_EMPTY,
    input  logic       FIFO_FULL,
    output logic       CPUACK,
    output logic       F2S,
    output logic       S2F,
    output logic       CPU2S,
    output logic       S2CPU,
    output logic       LS2CPU,
    output logic       BO1,
    output logic       BO0,
    output logic       SCSI_RE,
    output logic       SCSI_WE,
    output logic       DACK,
    output logic       INCFIFO,
    output logic       INCNI,
    output logic [1:0] DBG_STATE
);

    localparam logic [2:0] CNT_LAST = 3'(STROBE_CYCLES - 1);

    typedef struct packed {
        logic cpuack;
        logic f2s;
        logic s2f;
        logic cpu2s;
        logic s2cpu;
        logic ls2cpu;
        logic scsi_re;
        logic scsi_we;
        logic dack;
        logic incfifo;
        logic incni;
    } outs_t;

    state_t     state_q, state_d;
    acc_t       acc_q, acc_d;
    logic       rw_q, rw_d;
    logic       dir_q, dir_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] bo_q, bo_d;
    logic       last_cpu_q, last_cpu_d;
    logic       flush_pend_q, flush_pend_d;
    outs_t      out_q, out_d;

    logic dreq_s;
    logic fifo_ok;
    logic dma_rdy;
    logic flush_now;
    logic flush_incni;
    logic is_sel, is_strobe, is_hold, is_cpu;

    scsi_dreq_sync u_dreq_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (DREQ),
        .q_o   (dreq_s)
    );

    // CPUREQ/CPUACK: CPUREQ is a level held until the one-cycle CPUACK pulse;
    // a request still high in the IDLE after CPUACK starts a new access.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        rw_d         = rw_q;
        dir_d        = dir_q;
        cnt_d        = cnt_q;
        bo_d         = bo_q;
        last_cpu_d   = last_cpu_q;
        flush_pend_d = flush_pend_q | FLUSH;
        flush_incni  = 1'b0;

        fifo_ok   = (bo_q != 2'b00) | (DMADIR ? ~FIFO_EMPTY : ~FIFO_FULL);
        dma_rdy   = DMAENA & dreq_s & fifo_ok;
        flush_now = FLUSH | flush_pend_q;

        case (state_q)
            IDLE: begin
                dir_d = DMADIR;
                // A flush owns its IDLE cycle so BO is never cleared under a granted byte.
                if (flush_now) begin
                    flush_pend_d = 1'b0;
                    bo_d         = 2'b00;
                    flush_incni  = ~DMADIR & (bo_q != 2'b00);
                end else if (CPUREQ && (!dma_rdy || !last_cpu_q)) begin
                    state_d    = SETUP;
                    acc_d      = ACC_CPU;
                    rw_d       = CPURW;
                    last_cpu_d = 1'b1;
                end else if (dma_rdy) begin
                    state_d    = SETUP;
                    acc_d      = ACC_DMA;
                    last_cpu_d = 1'b0;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = 3'd0;
            end
            STROBE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            HOLD: begin
                state_d = IDLE;
                if (acc_q == ACC_DMA) begin
                    bo_d = bo_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so that they leave the flops
        // aligned with the state they belong to.
        is_sel    = (state_d != IDLE);
        is_strobe = (state_d == STROBE);
        is_hold   = (state_d == HOLD);
        is_cpu    = (acc_d == ACC_CPU);

        out_d.cpu2s   = is_sel & is_cpu & ~rw_d;
        out_d.s2cpu   = is_sel & is_cpu & rw_d;
        out_d.f2s     = is_sel & ~is_cpu & dir_d;
        out_d.s2f     = is_sel & ~is_cpu & ~dir_d;
        out_d.scsi_we = is_strobe & (is_cpu ? ~rw_d : dir_d);
        out_d.scsi_re = is_strobe & (is_cpu ? rw_d : ~dir_d);
        out_d.dack    = is_strobe & ~is_cpu;
        out_d.ls2cpu  = ~(is_strobe & is_cpu & rw_d & (cnt_d == CNT_LAST));
        out_d.cpuack  = is_hold & is_cpu;
        out_d.incfifo = is_hold & ~is_cpu & dir_d & (bo_q == BO_LAST);
        out_d.incni   = (is_hold & ~is_cpu & ~dir_d & (bo_q == BO_LAST)) | flush_incni;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            acc_q        <= ACC_CPU;
            rw_q         <= 1'b0;
            dir_q        <= 1'b0;
            cnt_q        <= 3'd0;
            bo_q         <= 2'b00;
            last_cpu_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            out_q        <= '0;
            out_q.ls2cpu <= 1'b1;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            rw_q         <= rw_d;
            dir_q        <= dir_d;
            cnt_q        <= cnt_d;
            bo_q         <= bo_d;
            last_cpu_q   <= last_cpu_d;
            flush_pend_q <= flush_pend_d;
            out_q        <= out_d;
        end
    end

    assign CPUACK    = out_q.cpuack;
    assign F2S       = out_q.f2s;
    assign S2F       = out_q.s2f;
    assign CPU2S     = out_q.cpu2s;
    assign S2CPU     = out_q.s2cpu;
    assign LS2CPU    = out_q.ls2cpu;
    assign SCSI_RE   = out_q.scsi_re;
    assign SCSI_WE   = out_q.scsi_we;
    assign DACK      = out_q.dack;
    assign INCFIFO   = out_q.incfifo;
    assign INCNI     = out_q.incni;
    assign BO1       = bo_q[1];
    assign BO0       = bo_q[0];
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_scsi_xfer_sequencer.sv
// Directed bench for scsi_xfer_sequencer at STROBE_CYCLES=2.
module tb_scsi_xfer_sequencer;

    logic CLK = 1'b0;
    logic RST, CPUREQ, CPURW, DMAENA, DMADIR, DREQ, FLUSH, FIFO_EMPTY, FIFO_FULL;
    logic CPUACK, F2S, S2F, CPU2S, S2CPU, LS2CPU, BO1, BO0;
    logic SCSI_RE, SCSI_WE, DACK, INCFIFO, INCNI;
    logic [1:0] DBG_STATE;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    scsi_xfer_sequencer #(.STROBE_CYCLES(2)) dut (
        .CLK(CLK), .RST(RST), .CPUREQ(CPUREQ), .CPURW(CPURW), .DMAENA(DMAENA),
        .DMADIR(DMADIR), .DREQ(DREQ), .FLUSH(FLUSH), .FIFO_EMPTY(FIFO_EMPTY),
        .FIFO_FULL(FIFO_FULL), .CPUACK(CPUACK), .F2S(F2S), .S2F(S2F), .CPU2S(CPU2S),
        .S2CPU(S2CPU), .LS2CPU(LS2CPU), .BO1(BO1), .BO0(BO0), .SCSI_RE(SCSI_RE),
        .SCSI_WE(SCSI_WE), .DACK(DACK), .INCFIFO(INCFIFO), .INCNI(INCNI),
        .DBG_STATE(DBG_STATE)
    );

    // Active-low outputs excluded; every bit here must be 0 at reset/idle.
    function automatic logic [11:0] low_outs();
        return {CPUACK, F2S, S2F, CPU2S, S2CPU, BO1, BO0, SCSI_RE, SCSI_WE, DACK, INCFIFO, INCNI};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST = 1'b1;
        CPUREQ = 0; CPURW = 0; DMAENA = 0; DMADIR = 0; DREQ = 0;
        FLUSH = 0; FIFO_EMPTY = 1; FIFO_FULL = 0;
        repeat (3) step();
        RST = 1'b0;
        step();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        CPUREQ = 0; CPURW = 0; DMAENA = 0; DMADIR = 0; DREQ = 0;
        FLUSH = 0; FIFO_EMPTY = 1; FIFO_FULL = 0;
        repeat (2) step();
        vectors++;
        if (low_outs() !== 12'h000) begin
            miscompares++; $display("FAIL reset_outs: got %b want %b", low_outs(), 12'h000);
        end
        vectors++;
        if (LS2CPU !== 1'b1) begin
            miscompares++; $display("FAIL reset_ls2cpu: got %b want 1", LS2CPU);
        end
        vectors++;
        if (DBG_STATE !== 2'd0) begin
            miscompares++; $display("FAIL reset_state: got %0d want 0", DBG_STATE);
        end
        RST = 1'b0;
        repeat (3) step();
        vectors++;
        if (low_outs() !== 12'h000 || LS2CPU !== 1'b1 || DBG_STATE !== 2'd0) begin
            miscompares++;
            $display("FAIL idle_after_reset: outs %b ls2cpu %b state %0d want 000000000000 1 0",
                     low_outs(), LS2CPU, DBG_STATE);
        end
    endtask

    task automatic test_cpu_access(input logic rw);
        int sel_cnt = 0, str_cnt = 0, ls_cnt = 0, ack_cnt = 0, bad_cnt = 0;
        int sel_first = -1, str_first = -1, ls_edge = -1, ack_edge = -1;
        CPURW = rw;
        CPUREQ = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (rw ? S2CPU : CPU2S) begin sel_cnt++; if (sel_first < 0) sel_first = i; end
            if (rw ? SCSI_RE : SCSI_WE) begin str_cnt++; if (str_first < 0) str_first = i; end
            if (!LS2CPU) begin ls_cnt++; ls_edge = i; end
            if (CPUACK) begin ack_cnt++; ack_edge = i; CPUREQ = 1'b0; end
            if ((rw ? SCSI_WE : SCSI_RE) || (rw ? CPU2S : S2CPU) || DACK || F2S || S2F) bad_cnt++;
        end
        vectors++;
        if (sel_cnt !== 4 || sel_first !== 1) begin
            miscompares++; $display("FAIL cpu%0d_select: got %0d cycles from edge %0d want 4 from 1", rw, sel_cnt, sel_first);
        end
        vectors++;
        if (str_cnt !== 2 || str_first !== 2) begin
            miscompares++; $display("FAIL cpu%0d_strobe: got %0d cycles from edge %0d want 2 from 2", rw, str_cnt, str_first);
        end
        vectors++;
        if (ls_cnt !== (rw ? 1 : 0) || ls_edge !== (rw ? 3 : -1)) begin
            miscompares++; $display("FAIL cpu%0d_ls2cpu: got %0d low at %0d want %0d at %0d",
                                    rw, ls_cnt, ls_edge, rw ? 1 : 0, rw ? 3 : -1);
        end
        // Edge 4 after the request cycle is the 5th cycle counting the request cycle.
        vectors++;
        if (ack_cnt !== 1 || ack_edge !== 4) begin
            miscompares++; $display("FAIL cpu%0d_ack: got %0d pulses at edge %0d want 1 at 4", rw, ack_cnt, ack_edge);
        end
        vectors++;
        if ({BO1, BO0} !== 2'b00 || bad_cnt !== 0) begin
            miscompares++; $display("FAIL cpu%0d_side: got bo %b stray %0d want bo 00 stray 0", rw, {BO1, BO0}, bad_cnt);
        end
    endtask

    task automatic test_f2s_word();
        int dack_cnt = 0, first_dack = -1, incfifo_cnt = 0, incni_cnt = 0, bad = 0;
        logic prev_dack = 1'b0;
        logic [1:0] bo_at [4];
        logic [1:0] incfifo_bo = 2'bxx;
        logic [1:0] k2;
        apply_reset();
        for (int k = 0; k < 4; k++) bo_at[k] = 2'bxx;
        DMAENA = 1; DMADIR = 1; FIFO_EMPTY = 0; DREQ = 1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (DACK && !prev_dack) begin
                if (dack_cnt < 4) bo_at[dack_cnt] = {BO1, BO0};
                dack_cnt++;
                if (first_dack < 0) first_dack = i;
            end
            if (DACK && !(SCSI_WE && F2S && !SCSI_RE)) bad++;
            if (INCFIFO) begin incfifo_cnt++; incfifo_bo = {BO1, BO0}; FIFO_EMPTY = 1; end
            if (INCNI) incni_cnt++;
            prev_dack = DACK;
        end
        DREQ = 0;
        vectors++;
        if (first_dack !== 4) begin
            miscompares++; $display("FAIL f2s_dreq_latency: got edge %0d want 4", first_dack);
        end
        vectors++;
        if (dack_cnt !== 4) begin
            miscompares++; $display("FAIL f2s_dack_count: got %0d want 4", dack_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            k2 = 2'(k);
            vectors++;
            if (bo_at[k] !== k2) begin
                miscompares++; $display("FAIL f2s_bo_byte%0d: got %b want %b", k, bo_at[k], k2);
            end
        end
        vectors++;
        if (incfifo_cnt !== 1 || incfifo_bo !== 2'b11 || incni_cnt !== 0) begin
            miscompares++; $display("FAIL f2s_incfifo: got %0d pulses at bo %b incni %0d want 1 at 11 incni 0",
                                    incfifo_cnt, incfifo_bo, incni_cnt);
        end
        vectors++;
        if ({BO1, BO0} !== 2'b00 || bad !== 0) begin
            miscompares++; $display("FAIL f2s_wrap: got bo %b strobe errors %0d want 00 0", {BO1, BO0}, bad);
        end
    endtask

    task automatic test_s2f_full();
        int dack_cnt = 0, first_dack = -1, bad = 0;
        logic prev_dack = 1'b0;
        apply_reset();
        DMAENA = 1; DMADIR = 0; FIFO_EMPTY = 0; FIFO_FULL = 1; DREQ = 1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (DACK) dack_cnt++;
        end
        vectors++;
        if (dack_cnt !== 0) begin
            miscompares++; $display("FAIL s2f_full_blocks: got %0d dack cycles want 0", dack_cnt);
        end
        FIFO_FULL = 0;
        dack_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (DACK && !prev_dack) begin
                dack_cnt++;
                if (first_dack < 0) begin first_dack = i; DMAENA = 0; end
            end
            if (DACK && !(SCSI_RE && S2F && !SCSI_WE)) bad++;
            prev_dack = DACK;
        end
        DREQ = 0;
        vectors++;
        if (first_dack !== 2 || bad !== 0) begin
            miscompares++; $display("FAIL s2f_release_latency: got edge %0d errors %0d want 2 0", first_dack, bad);
        end
        vectors++;
        if (dack_cnt !== 1 || {BO1, BO0} !== 2'b01 || S2F !== 1'b0 || DBG_STATE !== 2'd0) begin
            miscompares++; $display("FAIL s2f_dmaena_drop: got dacks %0d bo %b s2f %b state %0d want 1 01 0 0",
                                    dack_cnt, {BO1, BO0}, S2F, DBG_STATE);
        end
    endtask

    task automatic test_s2f_flush();
        int dack_cnt = 0, incni_cnt = 0;
        logic prev_dack = 1'b0;
        apply_reset();
        DMAENA = 1; DMADIR = 0; FIFO_EMPTY = 0; FIFO_FULL = 0; DREQ = 1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (DACK && !prev_dack) begin
                dack_cnt++;
                if (dack_cnt == 2) DMAENA = 0;
            end
            if (INCNI) incni_cnt++;
            prev_dack = DACK;
        end
        vectors++;
        if (dack_cnt !== 2 || {BO1, BO0} !== 2'b10 || incni_cnt !== 0) begin
            miscompares++; $display("FAIL s2f_two_bytes: got dacks %0d bo %b incni %0d want 2 10 0",
                                    dack_cnt, {BO1, BO0}, incni_cnt);
        end
        FLUSH = 1;
        step();
        FLUSH = 0;
        vectors++;
        if (INCNI !== 1'b1 || {BO1, BO0} !== 2'b00) begin
            miscompares++; $display("FAIL s2f_flush_pulse: got incni %b bo %b want 1 00", INCNI, {BO1, BO0});
        end
        incni_cnt = 0;
        dack_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (INCNI) incni_cnt++;
            if (DACK) dack_cnt++;
        end
        DREQ = 0;
        vectors++;
        if (incni_cnt !== 0 || dack_cnt !== 0 || {BO1, BO0} !== 2'b00) begin
            miscompares++; $display("FAIL s2f_flush_after: got extra incni %0d dack %0d bo %b want 0 0 00",
                                    incni_cnt, dack_cnt, {BO1, BO0});
        end
    endtask

    task automatic test_f2s_flush_pending();
        int pops = 0, found = 0;
        apply_reset();
        DMAENA = 1; DMADIR = 1; FIFO_EMPTY = 0; DREQ = 1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (DACK && found == 0) begin
                found = 1; DMAENA = 0; FLUSH = 1;
            end else begin
                FLUSH = 0;
            end
            if (INCFIFO || INCNI) pops++;
        end
        DREQ = 0;
        vectors++;
        if (found !== 1 || {BO1, BO0} !== 2'b00 || pops !== 0) begin
            miscompares++; $display("FAIL f2s_flush_pending: got byte %0d bo %b pops %0d want 1 00 0",
                                    found, {BO1, BO0}, pops);
        end
    endtask

    task automatic test_arbitration();
        logic seq [6];
        int n = 0, ack_cnt = 0;
        logic prev_cpu = 1'b0, prev_dma = 1'b0;
        logic want;
        apply_reset();
        for (int k = 0; k < 6; k++) seq[k] = 1'bx;
        CPURW = 1; CPUREQ = 1; DMAENA = 1; DMADIR = 1; FIFO_EMPTY = 0; DREQ = 1;
        for (int i = 1; i <= 100 && n < 6; i++) begin
            step();
            if (S2CPU && !prev_cpu) begin seq[n] = 1'b0; n++; end
            if (F2S && !prev_dma && n < 6) begin seq[n] = 1'b1; n++; end
            if (CPUACK) ack_cnt++;
            prev_cpu = S2CPU;
            prev_dma = F2S;
        end
        CPUREQ = 0; DMAENA = 0; DREQ = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (CPUACK) ack_cnt++;
        end
        vectors++;
        if (n !== 6) begin
            miscompares++; $display("FAIL arb_count: got %0d accesses want 6", n);
        end
        for (int k = 0; k < 6; k++) begin
            want = (k % 2 == 1);
            vectors++;
            if (seq[k] !== want) begin
                miscompares++; $display("FAIL arb_order%0d: got %s want %s", k,
                                        seq[k] ? "DMA" : "CPU", want ? "DMA" : "CPU");
            end
        end
        vectors++;
        if (ack_cnt !== 3 || {BO1, BO0} !== 2'b11) begin
            miscompares++; $display("FAIL arb_totals: got acks %0d bo %b want 3 11", ack_cnt, {BO1, BO0});
        end
    endtask

    task automatic test_reset_mid_access();
        int found = 0, pops = 0;
        apply_reset();
        DMAENA = 1; DMADIR = 1; FIFO_EMPTY = 0; DREQ = 1;
        for (int i = 1; i <= 60 && found == 0; i++) begin
            step();
            if (DACK && {BO1, BO0} == 2'b11) found = 1;
        end
        #3;
        RST = 1'b1;
        #1;
        vectors++;
        if (found !== 1 || {SCSI_RE, SCSI_WE, DACK, F2S, S2F} !== 5'b0 || {BO1, BO0} !== 2'b00 ||
            LS2CPU !== 1'b1 || DBG_STATE !== 2'd0) begin
            miscompares++; $display("FAIL rst_async: found %0d strobes %b bo %b ls2cpu %b state %0d want 1 00000 00 1 0",
                                    found, {SCSI_RE, SCSI_WE, DACK, F2S, S2F}, {BO1, BO0}, LS2CPU, DBG_STATE);
        end
        DMAENA = 0; DREQ = 0; FIFO_EMPTY = 1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 3) RST = 1'b0;
            if (INCFIFO || INCNI || CPUACK) pops++;
        end
        vectors++;
        if (pops !== 0) begin
            miscompares++; $display("FAIL rst_no_pulses: got %0d pulse cycles want 0", pops);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_access(1'b1);
        test_cpu_access(1'b0);
        test_f2s_word();
        test_s2f_full();
        test_s2f_flush();
        test_f2s_flush_pending();
        test_arbitration();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want completion before 200000ns");
        $fatal(1);
    end

endmodule
